// File: rtl/square_blitter.sv
// Renders one 30x30 board square (background, optional sprite, optional cursor border)
// into the VGA frame buffer at one pixel per clock, fed by a 1-cycle-latency sprite ROM.
module square_blitter #(
    parameter int unsigned BOARD_X0 = 40,
    parameter int unsigned SQ       = 30,
    parameter int unsigned ROM_AW   = 14
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [2:0]        square_x,
    input  logic [2:0]        square_y,
    input  logic [3:0]        piece,
    input  logic              highlight,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [1:0]        rom_data,
    output logic [8:0]        x,
    output logic [7:0]        y,
    output logic              colour,
    output logic              plot,
    output logic              busy,
    output logic              done
);

    localparam int unsigned     CntW    = $clog2(SQ);
    localparam logic [CntW-1:0] LastIdx = CntW'(SQ - 1);

    typedef enum logic [1:0] {StIdle, StDraw, StFlush, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] col_q, col_d, row_q, row_d;
    logic            accept;

    logic [2:0]      sq_x_q, sq_y_q;
    logic [3:0]      piece_q;
    logic            hl_q;

    logic            s1_valid_q;
    logic [CntW-1:0] s1_col_q, s1_row_q;

    logic [8:0]      x_q, x_d;
    logic [7:0]      y_q, y_d;
    logic            colour_q, colour_d;
    logic            plot_q;

    logic            piece_ok;
    logic            bg;
    logic            on_border;
    logic            sprite_hit;
    logic [ROM_AW-1:0] sprite_base;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    accept  = 1'b1;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = StDraw;
                end
            end
            StDraw: begin
                if (col_q == LastIdx) begin
                    col_d = '0;
                    if (row_q == LastIdx) begin
                        state_d = StFlush;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            // Wait until the stage-1 pixel of (29,29) has been written out.
            StFlush: begin
                if (!s1_valid_q) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        piece_ok    = (piece_q != 4'd0) && (piece_q <= 4'd12);
        sprite_base = ROM_AW'(piece_q - 4'd1) * ROM_AW'(SQ * SQ);
        rom_addr    = '0;
        if (state_q == StDraw && piece_ok) begin
            rom_addr = sprite_base + ROM_AW'(row_q) * ROM_AW'(SQ) + ROM_AW'(col_q);
        end
    end

    // rom_data now belongs to the stage-1 pixel; it only matters for real pieces.
    always_comb begin
        bg         = ~(sq_x_q[0] ^ sq_y_q[0]);
        on_border  = hl_q && (s1_row_q == '0 || s1_row_q == LastIdx ||
                              s1_col_q == '0 || s1_col_q == LastIdx);
        sprite_hit = piece_ok && (rom_data == 2'b01 || rom_data == 2'b10);
        x_d        = 9'(BOARD_X0) + 9'(sq_x_q) * 9'(SQ) + 9'(s1_col_q);
        y_d        = 8'(sq_y_q) * 8'(SQ) + 8'(s1_row_q);
        colour_d   = bg;
        if (on_border) begin
            colour_d = ~bg;
        end else if (sprite_hit) begin
            colour_d = rom_data[1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            sq_x_q     <= '0;
            sq_y_q     <= '0;
            piece_q    <= '0;
            hl_q       <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= 1'b0;
            plot_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            if (accept) begin
                sq_x_q  <= square_x;
                sq_y_q  <= square_y;
                piece_q <= piece;
                hl_q    <= highlight;
            end
            s1_valid_q <= (state_q == StDraw);
            s1_col_q   <= col_q;
            s1_row_q   <= row_q;
            plot_q     <= s1_valid_q;
            if (s1_valid_q) begin
                x_q      <= x_d;
                y_q      <= y_d;
                colour_q <= colour_d;
            end
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = (state_q == StDraw) || (state_q == StFlush);
    assign done   = (state_q == StDone);

endmodule

// File: tb/tb_square_blitter.sv
// Self-checking bench for square_blitter: a sprite ROM model plus a pixel-list reference
// built from the square/sprite/border rules, exercised with directed and random requests.
module tb_square_blitter;

    localparam int SQ = 30;
    localparam int BX = 40;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  square_x = '0;
    logic [2:0]  square_y = '0;
    logic [3:0]  piece = '0;
    logic        highlight = 1'b0;
    logic [13:0] rom_addr;
    logic [1:0]  rom_data;
    logic [8:0]  x;
    logic [7:0]  y;
    logic        colour, plot, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] rom_mem [0:16383];
    int         rom_mode = 0;

    // Per-request observations
    int         n_plots, first_plot_k, done_k, done_count;
    int         pix_err, busy_err, addr_err, stray;
    int         bad_n, bad_x, bad_y, bad_c, bad_want;
    int         first_addr, last_addr;
    int         first_x, first_y, last_x, last_y;

    always #5 clk = ~clk;

    square_blitter dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .square_x  (square_x),
        .square_y  (square_y),
        .piece     (piece),
        .highlight (highlight),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [1:0] rom_val(input int mode, input int addr);
        if (mode == 0) return rom_mem[addr];
        if (mode == 1) return (addr % 2 == 0) ? 2'b01 : 2'b11;
        return 2'b10;
    endfunction

    always @(posedge clk) rom_data <= rom_val(rom_mode, int'(rom_addr));

    // Pixel n of the square in raster order
    function automatic logic exp_colour(input int sx, input int sy, input int p, input int hl,
                                        input int n, input int mode);
        int r, c;
        bit bg;
        logic [1:0] d;
        r  = n / SQ;
        c  = n % SQ;
        bg = ((sx + sy) % 2) == 0;
        if (hl != 0 && (r == 0 || r == SQ - 1 || c == 0 || c == SQ - 1)) return !bg;
        if (p >= 1 && p <= 12) begin
            d = rom_val(mode, (p - 1) * SQ * SQ + n);
            if (d == 2'b01 || d == 2'b10) return d[1];
        end
        return bg;
    endfunction

    task automatic run_req(input string tag, input int sx, input int sy, input int p,
                           input int hl, input int poke_k, input bit chain, input int abort_n);
        int n;
        int exp_addr;
        bit exp_busy;
        logic want_c;
        n = 0; first_plot_k = -1; done_k = -1; done_count = 0;
        pix_err = 0; busy_err = 0; addr_err = 0; stray = 0;
        first_addr = -1; last_addr = -1;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        @(negedge clk);
        square_x = sx[2:0]; square_y = sy[2:0]; piece = p[3:0]; highlight = hl[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs: the latched request must be unaffected
        square_x = 3'($urandom); square_y = 3'($urandom);
        piece = 4'($urandom); highlight = 1'($urandom);
        for (int k = 0; k <= 904; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= 899) begin
                exp_addr = (p >= 1 && p <= 12) ? (p - 1) * SQ * SQ + k : 0;
                if (rom_addr !== 14'(exp_addr)) addr_err++;
                if (k == 0) first_addr = int'(rom_addr);
                if (k == 899) last_addr = int'(rom_addr);
            end
            exp_busy = (k <= 901) || (chain && k == 904);
            if (busy !== exp_busy) busy_err++;
            if (plot === 1'b1) begin
                if (k < 2 || k > 901 || n >= 900) begin
                    stray++;
                end else begin
                    want_c = exp_colour(sx, sy, p, hl, n, rom_mode);
                    if (x !== 9'(BX + sx * SQ + n % SQ) || y !== 8'(sy * SQ + n / SQ) ||
                        colour !== want_c) begin
                        if (pix_err == 0) begin
                            bad_n = n; bad_x = int'(x); bad_y = int'(y);
                            bad_c = int'(colour); bad_want = int'(want_c);
                        end
                        pix_err++;
                    end
                    if (n == 0) begin
                        first_plot_k = k; first_x = int'(x); first_y = int'(y);
                    end
                    last_x = int'(x); last_y = int'(y);
                    n++;
                end
            end else if (plot !== 1'b0) begin
                stray++;
            end
            if (done === 1'b1) begin
                done_count++;
                done_k = k;
            end
            if (k == poke_k) start = 1'b1;
            else if (k == poke_k + 1) start = 1'b0;
            if (chain && k == 902) start = 1'b1;
            if (chain && k == 904) start = 1'b0;
            if (abort_n > 0 && n == abort_n) begin
                resetn = 1'b0;
                #1;
                break;
            end
        end
        n_plots = n;
        if (abort_n <= 0) begin
            n_checks++;
            if (n_plots != 900) begin
                n_fail++; $display("FAIL %s plot_count: got %0d want 900", tag, n_plots);
            end
            n_checks++;
            if (first_plot_k != 2) begin
                n_fail++; $display("FAIL %s first_plot_cycle: got %0d want 2", tag, first_plot_k);
            end
            n_checks++;
            if (done_k != 902 || done_count != 1) begin
                n_fail++;
                $display("FAIL %s done: got cycle %0d count %0d want cycle 902 count 1",
                         tag, done_k, done_count);
            end
            n_checks++;
            if (pix_err != 0) begin
                n_fail++;
                $display("FAIL %s pixels: %0d bad, first n=%0d got (%0d,%0d) c=%0d want c=%0d",
                         tag, pix_err, bad_n, bad_x, bad_y, bad_c, bad_want);
            end
            n_checks++;
            if (busy_err != 0) begin
                n_fail++; $display("FAIL %s busy: %0d bad cycles want 0", tag, busy_err);
            end
            n_checks++;
            if (addr_err != 0) begin
                n_fail++; $display("FAIL %s rom_addr: %0d bad cycles want 0", tag, addr_err);
            end
            n_checks++;
            if (stray != 0) begin
                n_fail++; $display("FAIL %s stray_plot: got %0d want 0", tag, stray);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({plot, busy, done, colour} !== 4'b0 || x !== 9'd0 || y !== 8'd0 || rom_addr !== 14'd0)
        begin
            n_fail++;
            $display("FAIL reset_outputs: got plot=%b busy=%b done=%b x=%0d y=%0d c=%b addr=%0d want all 0",
                     plot, busy, done, x, y, colour, rom_addr);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({plot, busy, done} !== 3'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got plot=%b busy=%b done=%b want 0", plot, busy, done);
        end
    endtask

    task automatic test_empty_square();
        rom_mode = 0;
        run_req("empty", 0, 0, 0, 0, -5, 1'b0, 0);
        n_checks++;
        if (first_x != 40 || first_y != 0 || last_x != 69 || last_y != 29) begin
            n_fail++;
            $display("FAIL empty_corners: got (%0d,%0d)..(%0d,%0d) want (40,0)..(69,29)",
                     first_x, first_y, last_x, last_y);
        end
    endtask

    task automatic test_border();
        rom_mode = 0;
        run_req("border", 1, 0, 0, 1, -5, 1'b0, 0);
        n_checks++;
        if (first_x != 70 || last_x != 99 || last_y != 29) begin
            n_fail++;
            $display("FAIL border_corners: got first x=%0d last (%0d,%0d) want 70 (99,29)",
                     first_x, last_x, last_y);
        end
    endtask

    task automatic test_sprite();
        rom_mode = 1;
        run_req("sprite", 7, 7, 12, 0, -5, 1'b0, 0);
        n_checks++;
        if (first_addr != 9900 || last_addr != 10799) begin
            n_fail++;
            $display("FAIL sprite_addr_range: got %0d..%0d want 9900..10799", first_addr, last_addr);
        end
        n_checks++;
        if (last_x != 279 || last_y != 239) begin
            n_fail++;
            $display("FAIL sprite_last_pixel: got (%0d,%0d) want (279,239)", last_x, last_y);
        end
    endtask

    task automatic test_piece13();
        rom_mode = 2;
        run_req("piece13", int'($urandom_range(7)), int'($urandom_range(7)), 13, 0, -5, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        int waited;
        rom_mode = 0;
        run_req("b2b", 2, 5, 3, 1, 100, 1'b1, 0);
        waited = 0;
        while (done !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second_done: got done=%b want 1 within 1000 cycles", done);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int bad;
        rom_mode = 0;
        run_req("abort", 3, 4, 5, 1, -5, 1'b0, 450);
        n_checks++;
        if (n_plots != 450 || {plot, busy, done} !== 3'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: plots=%0d plot=%b busy=%b done=%b want 450 0 0 0",
                     n_plots, plot, busy, done);
        end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (plot !== 1'b0 || done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad);
        end
        resetn = 1'b1;
        @(negedge clk);
        run_req("after_abort", int'($urandom_range(7)), int'($urandom_range(7)),
                int'($urandom_range(1, 12)), int'($urandom_range(1)), -5, 1'b0, 0);
    endtask

    task automatic test_random();
        rom_mode = 0;
        for (int i = 0; i < 4; i++) begin
            run_req("random", int'($urandom_range(7)), int'($urandom_range(7)),
                    int'($urandom_range(15)), int'($urandom_range(1)), -5, 1'b0, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom_mem[i] = 2'($urandom);
        test_reset();
        test_empty_square();
        test_border();
        test_sprite();
        test_back_to_back();
        test_abort();
        test_piece13();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/square_blitter.md
Name: square_blitter

Overview:
- Draws one 30x30 board square into the VGA adapter frame buffer, one pixel per clock. The square's background is set by board parity, an optional piece sprite is overlaid, and an optional cursor border can be added.
- Sits between view_render, which issues one request per changed square, and vga_adapter, which consumes x/y/colour/plot.
- Sprites are read from an external synchronous sprite ROM with 1-cycle read latency. The 320x240 monochrome mode is used.

Parameters:
- BOARD_X0, 40: x pixel offset of the board's left edge. The board is 240 px wide, centred in 320.
- SQ, 30: square edge in pixels.
- ROM_AW, 14: sprite ROM address width. 12 sprites x 900 px = 10800 words.

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset
- start  in  1  request strobe; sampled only in IDLE
- square_x  in  3  board column 0..7
- square_y  in  3  board row 0..7
- piece  in  4  piece code per the board lookup table (0 = empty, 1..12 = pieces)
- highlight  in  1  draw cursor border
- rom_addr  out  ROM_AW  sprite ROM address
- rom_data  in  2  sprite pixel: 00 transparent, 01 black, 10 white, 11 transparent
- x  out  9  pixel x to vga_adapter
- y  out  8  pixel y to vga_adapter
- colour  out  1  pixel colour (1 = white)
- plot  out  1  write strobe to vga_adapter
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - plot, busy and done go to 0. x, y, colour and rom_addr go to 0.
  - Latched request fields and counters clear.
- States: IDLE, DRAW, FLUSH, DONE.
- IDLE:
  - When start=1, latch square_x, square_y, piece and highlight. Set col=0, row=0. Go to DRAW.
  - busy rises on the next cycle.
- DRAW:
  - Each cycle, present rom_addr = (piece-1)*900 + row*30 + col for pieces 1..12. For piece 0 or 13..15, present rom_addr = 0.
  - Advance col 0..29; on col wrap, increment row.
  - After the (row,col)=(29,29) address is presented, go to FLUSH.
- Stage-1 register (pipeline, one cycle behind the address):
  - x = BOARD_X0 + sq_x*30 + col_d; y = sq_y*30 + row_d. Both are computed at full width with no overflow; the maximum is x=279, y=239.
  - plot=1 for every stage-1 valid pixel.
- Colour priority, highest first:
  1. Border: highlight=1 and (row_d or col_d in {0,29}) → colour = ~bg.
  2. Sprite: piece in 1..12 and rom_data in {01,10} → colour = rom_data[1].
  3. Background: colour = bg, where bg = 1 when (sq_x+sq_y) is even and 0 otherwise.
- Timing:
  - First plot occurs 2 cycles after the start-accepting edge.
  - Exactly 900 consecutive plot cycles follow, in raster order (row-major, col fastest).
- FLUSH: emits the final pixel (29,29), then goes to DONE.
- DONE:
  - done=1 for exactly one cycle; plot=0 and busy=0 in this cycle.
  - Returns to IDLE.
  - Total occupancy is 902 cycles from the accept edge to done.
- busy is high from the cycle after acceptance through the last plot cycle.
- start while not in IDLE (including in DONE) is ignored and never queued. Input changes after acceptance have no effect.
- Reset asserted mid-draw aborts immediately: no further plot and no done pulse.
- rom_data is ignored (not X-propagated) when piece is 0 or 13..15.

Test Plan:
- Reset, then start with sq(0,0), piece=0, highlight=0 → 900 plots, all colour=1; first pixel (40,0) 2 cycles after start; last pixel (69,29); done pulses 902 cycles after the accept edge.
- sq(1,0), piece=0, highlight=1 → bg=0; border pixels (x=70 or 99, y=0 or 29) colour=1; interior colour=0.
- sq(7,7), piece=12, ROM model returns 01 for even addresses and 11 for odd → rom_addr runs 9900..10799; even-address pixels colour=0, odd-address pixels colour=bg=1; last pixel (279,239).
- Pulse start again at cycle 100 of a draw → ignored; exactly one done; new start accepted in the cycle after done.
- Assert resetn=0 at plot #450 → plot, busy and done go to 0 immediately; after release, IDLE accepts a new request normally.
- piece=13, with rom_data driven to 10 → treated as empty; all pixels show bg.
